// File: rtl/add_sub_pipe_if.sv
// Streaming operand/result bus for add_sub_pipe: valid/ready on both the operand and result sides.
interface add_sub_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, s, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, s, c_out, ovf
   );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor, one WIDTH/STAGES-bit carry slice per stage.
// Define ADD_SUB_PIPE_SATURATE_EN to clamp s to the signed limit on overflow.
module add_sub_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic          clk,
   input  logic          rst,
   add_sub_pipe_if.slave bus
);
   localparam int unsigned SW   = WIDTH / STAGES;
   localparam int unsigned SW1  = SW + 1;
   localparam int unsigned LAST = STAGES - 1;

   logic adv;
   logic ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // RW: operand bits still to be summed; LW: result bits produced so far
      localparam int unsigned RW = WIDTH - k * SW;
      localparam int unsigned LW = (k + 1) * SW;

      logic [RW-1:0] op_a;
      logic [RW-1:0] op_b;
      logic          op_c;
      logic          op_v;
      logic [SW:0]   sum;
      logic [LW-1:0] res;
      logic [LW-1:0] nxt;
      logic [LW-1:0] s_r;
      logic          c_r;
      logic          v_r;

      // Subtraction folds into the first stage as a + ~b + ~c_in
      if (k == 0) begin : g_head
         assign op_a = bus.a;
         assign op_b = bus.sub ? ~bus.b : bus.b;
         assign op_c = bus.sub ? ~bus.c_in : bus.c_in;
         assign op_v = bus.in_valid;
         assign res  = sum[SW-1:0];
      end else begin : g_body
         assign op_a = g_stage[k-1].g_skew.a_r;
         assign op_b = g_stage[k-1].g_skew.b_r;
         assign op_c = g_stage[k-1].c_r;
         assign op_v = g_stage[k-1].v_r;
         assign res  = {sum[SW-1:0], g_stage[k-1].s_r};
      end

      assign sum = SW1'(op_a[SW-1:0]) + SW1'(op_b[SW-1:0]) + SW1'(op_c);

      if (k < LAST) begin : g_skew
         logic [RW-SW-1:0] a_r;
         logic [RW-SW-1:0] b_r;

         assign nxt = res;

         // Unconsumed upper operand slices travel alongside their beat
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_r <= '0;
               b_r <= '0;
            end else if (adv) begin
               a_r <= op_a[RW-1:SW];
               b_r <= op_b[RW-1:SW];
            end
         end
      end else begin : g_tail
         logic msb_cin;
         logic ovf_n;

         // Carry into the MSB recovered from the MSB sum bit
         assign msb_cin = op_a[SW-1] ^ op_b[SW-1] ^ sum[SW-1];
         assign ovf_n   = msb_cin ^ sum[SW];

`ifdef ADD_SUB_PIPE_SATURATE_EN
         assign nxt = !ovf_n ? res
                    : (op_a[SW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}});
`else
         assign nxt = res;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_n;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s_r <= '0;
            c_r <= 1'b0;
            v_r <= 1'b0;
         end else if (adv) begin
            s_r <= nxt;
            c_r <= sum[SW];
            v_r <= op_v;
         end
      end
   end

   // Whole pipe advances in lockstep whenever the output slot is free or draining
   assign adv           = !g_stage[LAST].v_r || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = g_stage[LAST].v_r;
   assign bus.s         = g_stage[LAST].s_r;
   assign bus.c_out     = g_stage[LAST].c_r;
   assign bus.ovf       = ovf_q;
endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's single-cycle 32-bit full adder.
- Splits the WIDTH-bit add into STAGES carry-chained slices, one slice per clock, for timing closure at wide widths.
- Valid/ready handshake on both sides so it drops into streaming datapaths.
- Reports carry-out and signed overflow; optional signed saturation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; slice width SW = WIDTH/STAGES; STAGES=1 is legal (single-register adder).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: add, 1: subtract
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- c_out  output  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Reset (async, immediate): all stage valid bits, s, c_out, ovf, out_valid = 0. In-flight beats discarded. in_ready = 1 from the first cycle after rst deasserts.
- Arithmetic:
  - add: {c_out, s} = a + b + c_in.
  - sub: b' = ~b, cin' = ~c_in, {c_out, s} = a + b' + cin', i.e. s = a - b - c_in mod 2^WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k (bits k*SW+SW-1 : k*SW) of the operands using the registered carry from stage k-1; stage 0 uses cin'.
  - Higher operand slices are skew-registered alongside; lower result slices are deskew-registered so s emerges aligned.
  - sub, a[MSB] and the MSB carry-in are carried to the last stage for ovf/saturation.
- Advance rule: adv = !out_valid || out_ready. All stages shift together when adv = 1 and hold otherwise. in_ready = adv, combinational.
- Accept when in_valid && in_ready. Bubbles (in_valid = 0 with adv = 1) propagate as invalid stages.
- Latency: accepted beat appears at out_valid exactly STAGES cycles later, assuming no stall. Throughput: 1 beat/cycle.
- out_valid && !out_ready: s, c_out, ovf, out_valid hold stable until the handshake completes; no beat is dropped or duplicated; order is preserved.
- Simultaneous output handshake and input accept in the same cycle are legal; pipeline stays full.
- s, c_out and ovf are don't-care when out_valid = 0. They must not toggle while out_valid = 1 and out_ready = 0.
- Wrap-around: results are modulo 2^WIDTH; no exceptions or traps.

Optional Feature:
- Macro: ADD_SUB_PIPE_SATURATE_EN.
- Defined: on ovf = 1, s clamps in the final stage.
  - a[MSB] = 0 → s = {0, all 1s} (max positive).
  - a[MSB] = 1 → s = {1, all 0s} (min negative).
  - ovf is still asserted; c_out is unaffected; latency unchanged.
- Undefined: s is the wrapped result; no extra logic is synthesised.

Test Plan (WIDTH=32, STAGES=4):
- add 256 + 256, c_in=0 → after 4 cycles s=512, c_out=0, ovf=0; 4 + 35 → s=39.
- add 0xFFFFFFFF + 2 → s=1, c_out=1, ovf=0. 0x7FFFFFFF + 1 → s=0x80000000, ovf=1, c_out=0 (SATURATE_EN: s=0x7FFFFFFF, ovf=1).
- sub 10 - 3, c_in=0 → s=7, c_out=1. sub 3 - 10 → s=0xFFFFFFF9, c_out=0, ovf=0. sub 0x80000000 - 1 → s=0x7FFFFFFF, ovf=1 (SATURATE_EN: s=0x80000000).
- Carry across every slice boundary: 0x00FFFFFF + 1 → 0x01000000. 0x0000FFFF + 0x00000001 with c_in=1 → 0x00010001.
- Backpressure: 6 back-to-back beats, out_ready low 3 cycles mid-stream → in_ready low during the stall; all 6 results delivered in order with values held stable while stalled; zero loss or duplication.
- Reset mid-operation: pipeline full, assert rst for 1 cycle → out_valid=0 immediately. No stale result emerges afterwards. A fresh beat yields its correct result 4 cycles after acceptance.
